simt_reconvergence_stack: RTL and testbench
===========================================

// Module: simt_reconvergence_stack
// PURPOSE
//   Per-warp SIMT reconvergence stack for the compute-unit fetcher. Tracks PC and active mask
//   of every warp, splits a warp on divergent branches reported by decode and rejoins threads
//   at the reconvergence PC. Also does warp allocation for new thread blocks and thread-block
//   completion. Sits between block dispatch, decode, instruction buffer and fetcher.
// PARAMETERS
//   PcWidth       32  program counter width
//   NumWarps       8  warps per compute unit
//   WarpWidth     32  threads per warp
//   StackDepth     4  stack entries per warp incl. base entry; >=3
//   TblockIdxBits  4  block index width
//   TblockIdBits   4  block id width
//   AddressWidth  32  data/parameter address width
// PORTS
//   clk_i                      in   1            clock
//   rst_i                      in   1            async reset, active-high
//   warp_free_o                out  1            >=1 unoccupied warp
//   allocate_warp_i            in   1            start block in lowest free warp
//   allocate_pc_i              in   PcWidth      start PC
//   allocate_dp_addr_i         in   AddressWidth data/parameter address
//   allocate_tblock_idx_i      in   TblockIdxBits block index
//   allocate_tblock_id_i       in   TblockIdBits block id
//   tblock_done_o              out  1            block done valid
//   tblock_done_ready_i        in   1            block done ready
//   tblock_done_id_o           out  TblockIdBits id of done block
//   instruction_decoded_i      in   1            decode result valid for decode_wid_i
//   decode_wid_i               in   WidWidth     decoded warp id
//   decode_next_pc_i           in   PcWidth      fall-through PC
//   decode_stop_warp_i         in   1            warp executes stop
//   decode_branch_i            in   1            instruction is conditional branch
//   decode_taken_mask_i        in   WarpWidth    threads taking branch
//   decode_target_pc_i         in   PcWidth      branch target
//   decode_reconv_pc_i         in   PcWidth      reconvergence PC (immediate post-dominator)
//   ib_all_instr_finished_i    in   NumWarps     no instructions in flight per warp
//   warp_selected_i            in   NumWarps     fetcher picked warp (one-hot or zero)
//   warp_ready_o               out  NumWarps     warp fetchable
//   warp_pc_o                  out  NumWarps*PcWidth    top-of-stack (TOS) PC
//   warp_act_mask_o            out  NumWarps*WarpWidth  TOS active mask
//   warp_dp_addr_o             out  NumWarps*AddressWidth
//   warp_tblock_idx_o          out  NumWarps*TblockIdxBits
//   stack_overflow_o           out  1            pulse: divergence with no room
//   stack_overflow_wid_o       out  WidWidth     warp that overflowed
// BEHAVIOUR
//   Reset: all warps unoccupied, depth 0, all outputs 0 (warp_free_o=1 once out of reset).
//   Entry = {pc, mask, rpc}. Per-warp depth counter, 1..StackDepth when occupied. TOS drives outputs.
//   Allocate (allocate_warp_i && warp_free_o): lowest unoccupied warp (by registered state);
//     entry0={allocate_pc_i,'1,'1}, depth=1, ready=1, finished=0. A warp freed this cycle is not reused.
//   Select: warp_selected_i[i] clears ready next cycle; ready stays 0 until decode of that warp.
//   Decode update (one warp/cycle), act = TOS mask, t = act & decode_taken_mask_i:
//     stop: finished=1, ready=0; branch fields ignored.
//     non-branch or t==0: TOS.pc=next_pc. t==act: TOS.pc=target_pc.
//     divergent (0<t<act), depth+2<=StackDepth: TOS.pc=reconv_pc; push {next_pc, act&~t, reconv_pc};
//       push {target_pc, t, reconv_pc}; depth+=2. Taken path runs first.
//     divergent, no room: stack unchanged, finished=1, ready=0, stack_overflow_o=1 for one cycle.
//     then ready=1 (unless finished); if depth>1 and new TOS.pc==TOS.rpc, pop (depth-=1) same cycle.
//       At most one pop per decode; lower entry continues next fetch.
//   Latency: decode update visible on warp_pc_o/warp_ready_o the following cycle.
//   warp_ready_o[i] = ready && occupied && |TOS.mask.
//   Done: lowest warp with occupied && finished && ib_all_instr_finished_i drives tblock_done_o,
//     id combinationally; on ready handshake warp freed (occupied=0, depth=0). Other finished warps wait.
//   Simultaneous alloc + done of different warps both take effect; select and decode of same warp
//     in one cycle is illegal (assertion), as is decode/select of unoccupied warp.
//   Reset mid-operation: all stacks discarded immediately, no done reported.
// TESTING
//   Alloc pc=0x100, select, decode next=0x104 -> cycle after: pc 0x104, ready=1, mask 0xFFFFFFFF.
//   Branch taken=0x0000FFFF target=0x200 reconv=0x300 next=0x104 -> pc 0x200 mask 0x0000FFFF, depth 3;
//     decode next=0x300 -> pop, pc 0x104 mask 0xFFFF0000; decode next=0x300 -> pop, pc 0x300 mask all.
//   Uniform taken=0xFFFFFFFF target=0x400 -> pc 0x400, depth unchanged; taken=0 -> pc next_pc.
//   StackDepth=3, nested divergence at depth 3 -> stack_overflow_o=1, wid correct, warp finishes.
//   Warps 1,3 stop, ib finished, ready low 2 cycles -> done_o held with warp 1 id; handshake frees 1, then 3.
//   All warps occupied -> warp_free_o=0, allocate ignored; rst_i mid-divergence -> all outputs 0.

Source files
------------

// File: rtl/simt_reconvergence_stack.sv
// Per-warp SIMT reconvergence stacks: warp allocation, divergence split/rejoin on decode
// results, fetch readiness and thread-block completion handshake.
module simt_reconvergence_stack #(
    parameter int PcWidth       = 32,
    parameter int NumWarps      = 8,
    parameter int WarpWidth     = 32,
    parameter int StackDepth    = 4,
    parameter int TblockIdxBits = 4,
    parameter int TblockIdBits  = 4,
    parameter int AddressWidth  = 32,
    localparam int WidWidth     = $clog2(NumWarps)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    output logic                              warp_free_o,
    input  logic                              allocate_warp_i,
    input  logic [PcWidth-1:0]                allocate_pc_i,
    input  logic [AddressWidth-1:0]           allocate_dp_addr_i,
    input  logic [TblockIdxBits-1:0]          allocate_tblock_idx_i,
    input  logic [TblockIdBits-1:0]           allocate_tblock_id_i,
    output logic                              tblock_done_o,
    input  logic                              tblock_done_ready_i,
    output logic [TblockIdBits-1:0]           tblock_done_id_o,
    input  logic                              instruction_decoded_i,
    input  logic [WidWidth-1:0]               decode_wid_i,
    input  logic [PcWidth-1:0]                decode_next_pc_i,
    input  logic                              decode_stop_warp_i,
    input  logic                              decode_branch_i,
    input  logic [WarpWidth-1:0]              decode_taken_mask_i,
    input  logic [PcWidth-1:0]                decode_target_pc_i,
    input  logic [PcWidth-1:0]                decode_reconv_pc_i,
    input  logic [NumWarps-1:0]               ib_all_instr_finished_i,
    input  logic [NumWarps-1:0]               warp_selected_i,
    output logic [NumWarps-1:0]               warp_ready_o,
    output logic [NumWarps*PcWidth-1:0]       warp_pc_o,
    output logic [NumWarps*WarpWidth-1:0]     warp_act_mask_o,
    output logic [NumWarps*AddressWidth-1:0]  warp_dp_addr_o,
    output logic [NumWarps*TblockIdxBits-1:0] warp_tblock_idx_o,
    output logic                              stack_overflow_o,
    output logic [WidWidth-1:0]               stack_overflow_wid_o
);
    localparam int DepthW = $clog2(StackDepth + 1);
    localparam int IdxW   = $clog2(StackDepth);

    logic [NumWarps-1:0]      occupied_q, finished_q, ready_q;
    logic [DepthW-1:0]        depth_q [NumWarps];
    logic [PcWidth-1:0]       stk_pc_q   [NumWarps][StackDepth];
    logic [WarpWidth-1:0]     stk_mask_q [NumWarps][StackDepth];
    logic [PcWidth-1:0]       stk_rpc_q  [NumWarps][StackDepth];
    logic [AddressWidth-1:0]  dp_q  [NumWarps];
    logic [TblockIdxBits-1:0] idx_q [NumWarps];
    logic [TblockIdBits-1:0]  id_q  [NumWarps];
    logic                     ovf_q;
    logic [WidWidth-1:0]      ovf_wid_q;

    logic                free_vld, done_vld, alloc_fire, done_fire;
    logic [WidWidth-1:0] free_idx, done_idx;

    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        done_vld = 1'b0;
        done_idx = '0;
        for (int i = NumWarps - 1; i >= 0; i--) begin
            if (!occupied_q[i]) begin
                free_vld = 1'b1;
                free_idx = WidWidth'(i);
            end
            if (occupied_q[i] && finished_q[i] && ib_all_instr_finished_i[i]) begin
                done_vld = 1'b1;
                done_idx = WidWidth'(i);
            end
        end
    end

    assign alloc_fire       = allocate_warp_i && free_vld;
    assign done_fire        = done_vld && tblock_done_ready_i;
    assign warp_free_o      = free_vld && !rst_i;
    assign tblock_done_o    = done_vld;
    assign tblock_done_id_o = done_vld ? id_q[done_idx] : '0;

    logic [DepthW-1:0]    dec_depth, dec_new_depth;
    logic [IdxW-1:0]      dec_tos, dec_push0, dec_push1;
    logic [WarpWidth-1:0] dec_act, dec_taken;
    logic [PcWidth-1:0]   dec_uni_pc, dec_top_pc, dec_top_rpc;
    logic                 dec_divergent, dec_room, dec_ok, dec_pop;

    // The post-update TOS is the taken path when we split, else the same entry with a new PC.
    always_comb begin
        dec_depth     = depth_q[decode_wid_i];
        dec_tos       = IdxW'(dec_depth - DepthW'(1));
        dec_push0     = IdxW'(dec_depth);
        dec_push1     = IdxW'(dec_depth + DepthW'(1));
        dec_act       = stk_mask_q[decode_wid_i][dec_tos];
        dec_taken     = dec_act & decode_taken_mask_i;
        dec_divergent = decode_branch_i && (dec_taken != '0) && (dec_taken != dec_act);
        dec_room      = (int'(dec_depth) + 2) <= StackDepth;
        dec_uni_pc    = (decode_branch_i && (dec_taken == dec_act)) ? decode_target_pc_i
                                                                    : decode_next_pc_i;
        if (dec_divergent) begin
            dec_top_pc    = decode_target_pc_i;
            dec_top_rpc   = decode_reconv_pc_i;
            dec_new_depth = dec_depth + DepthW'(2);
        end else begin
            dec_top_pc    = dec_uni_pc;
            dec_top_rpc   = stk_rpc_q[decode_wid_i][dec_tos];
            dec_new_depth = dec_depth;
        end
        dec_ok  = instruction_decoded_i && !decode_stop_warp_i && !(dec_divergent && !dec_room);
        dec_pop = (dec_new_depth > DepthW'(1)) && (dec_top_pc == dec_top_rpc);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occupied_q <= '0;
            finished_q <= '0;
            ready_q    <= '0;
            ovf_q      <= 1'b0;
            ovf_wid_q  <= '0;
            for (int i = 0; i < NumWarps; i++) depth_q[i] <= '0;
        end else begin
            ovf_q   <= 1'b0;
            ready_q <= ready_q & ~warp_selected_i;
            if (done_fire) begin
                occupied_q[done_idx] <= 1'b0;
                ready_q[done_idx]    <= 1'b0;
                depth_q[done_idx]    <= '0;
            end
            if (alloc_fire) begin
                occupied_q[free_idx] <= 1'b1;
                finished_q[free_idx] <= 1'b0;
                ready_q[free_idx]    <= 1'b1;
                depth_q[free_idx]    <= DepthW'(1);
            end
            if (instruction_decoded_i && (decode_stop_warp_i || (dec_divergent && !dec_room))) begin
                finished_q[decode_wid_i] <= 1'b1;
                ready_q[decode_wid_i]    <= 1'b0;
                if (!decode_stop_warp_i) begin
                    ovf_q     <= 1'b1;
                    ovf_wid_q <= decode_wid_i;
                end
            end else if (dec_ok) begin
                ready_q[decode_wid_i] <= !finished_q[decode_wid_i];
                depth_q[decode_wid_i] <= dec_new_depth - DepthW'(dec_pop);
            end
        end
    end

    // Stack contents carry no reset; outputs are gated by occupancy instead.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            stk_pc_q[free_idx][0]   <= allocate_pc_i;
            stk_mask_q[free_idx][0] <= '1;
            stk_rpc_q[free_idx][0]  <= '1;
            dp_q[free_idx]          <= allocate_dp_addr_i;
            idx_q[free_idx]         <= allocate_tblock_idx_i;
            id_q[free_idx]          <= allocate_tblock_id_i;
        end
        if (dec_ok) begin
            if (dec_divergent) begin
                stk_pc_q[decode_wid_i][dec_tos]     <= decode_reconv_pc_i;
                stk_pc_q[decode_wid_i][dec_push0]   <= decode_next_pc_i;
                stk_mask_q[decode_wid_i][dec_push0] <= dec_act & ~dec_taken;
                stk_rpc_q[decode_wid_i][dec_push0]  <= decode_reconv_pc_i;
                stk_pc_q[decode_wid_i][dec_push1]   <= decode_target_pc_i;
                stk_mask_q[decode_wid_i][dec_push1] <= dec_taken;
                stk_rpc_q[decode_wid_i][dec_push1]  <= decode_reconv_pc_i;
            end else begin
                stk_pc_q[decode_wid_i][dec_tos] <= dec_uni_pc;
            end
        end
    end

    for (genvar g = 0; g < NumWarps; g++) begin : g_out
        logic [IdxW-1:0] tos;
        assign tos = IdxW'(depth_q[g] - DepthW'(1));
        assign warp_pc_o[g*PcWidth +: PcWidth] = occupied_q[g] ? stk_pc_q[g][tos] : '0;
        assign warp_act_mask_o[g*WarpWidth +: WarpWidth] =
            occupied_q[g] ? stk_mask_q[g][tos] : '0;
        assign warp_dp_addr_o[g*AddressWidth +: AddressWidth] = occupied_q[g] ? dp_q[g] : '0;
        assign warp_tblock_idx_o[g*TblockIdxBits +: TblockIdxBits] =
            occupied_q[g] ? idx_q[g] : '0;
        assign warp_ready_o[g] = ready_q[g] && occupied_q[g] && (stk_mask_q[g][tos] != '0);
    end

    assign stack_overflow_o     = ovf_q;
    assign stack_overflow_wid_o = ovf_wid_q;

    assert property (@(posedge clk_i) disable iff (rst_i)
        !(instruction_decoded_i && warp_selected_i[decode_wid_i]));
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(instruction_decoded_i && !occupied_q[decode_wid_i]));
    assert property (@(posedge clk_i) disable iff (rst_i)
        (warp_selected_i & ~occupied_q) == '0);
endmodule

// File: tb/tb_simt_reconvergence_stack.sv
// Bench for simt_reconvergence_stack: directed table, hand sequences, then random traffic
// against a queue-based reference model.
module tb_simt_reconvergence_stack;
    localparam int PW = 32, NW = 8, WW = 32, SD = 4, IXB = 4, IDB = 4, AW = 32, WIDW = 3;

    logic clk = 1'b0, rst_i = 1'b1;
    logic warp_free_o, allocate_warp_i, tblock_done_o, tblock_done_ready_i;
    logic [PW-1:0] allocate_pc_i, decode_next_pc_i, decode_target_pc_i, decode_reconv_pc_i;
    logic [AW-1:0] allocate_dp_addr_i;
    logic [IXB-1:0] allocate_tblock_idx_i;
    logic [IDB-1:0] allocate_tblock_id_i, tblock_done_id_o;
    logic instruction_decoded_i, decode_stop_warp_i, decode_branch_i, stack_overflow_o;
    logic [WIDW-1:0] decode_wid_i, stack_overflow_wid_o;
    logic [WW-1:0] decode_taken_mask_i;
    logic [NW-1:0] ib_all_instr_finished_i, warp_selected_i, warp_ready_o;
    logic [NW*PW-1:0] warp_pc_o;
    logic [NW*WW-1:0] warp_act_mask_o;
    logic [NW*AW-1:0] warp_dp_addr_o;
    logic [NW*IXB-1:0] warp_tblock_idx_o;

    simt_reconvergence_stack dut (
        .clk_i(clk), .rst_i(rst_i), .warp_free_o(warp_free_o),
        .allocate_warp_i(allocate_warp_i), .allocate_pc_i(allocate_pc_i),
        .allocate_dp_addr_i(allocate_dp_addr_i), .allocate_tblock_idx_i(allocate_tblock_idx_i),
        .allocate_tblock_id_i(allocate_tblock_id_i), .tblock_done_o(tblock_done_o),
        .tblock_done_ready_i(tblock_done_ready_i), .tblock_done_id_o(tblock_done_id_o),
        .instruction_decoded_i(instruction_decoded_i), .decode_wid_i(decode_wid_i),
        .decode_next_pc_i(decode_next_pc_i), .decode_stop_warp_i(decode_stop_warp_i),
        .decode_branch_i(decode_branch_i), .decode_taken_mask_i(decode_taken_mask_i),
        .decode_target_pc_i(decode_target_pc_i), .decode_reconv_pc_i(decode_reconv_pc_i),
        .ib_all_instr_finished_i(ib_all_instr_finished_i), .warp_selected_i(warp_selected_i),
        .warp_ready_o(warp_ready_o), .warp_pc_o(warp_pc_o), .warp_act_mask_o(warp_act_mask_o),
        .warp_dp_addr_o(warp_dp_addr_o), .warp_tblock_idx_o(warp_tblock_idx_o),
        .stack_overflow_o(stack_overflow_o), .stack_overflow_wid_o(stack_overflow_wid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pc;
        logic [WW-1:0] mask;
        logic [PW-1:0] rpc;
    } entry_t;

    entry_t         m_stk [NW][$];
    bit             m_occ [NW];
    bit             m_fin [NW];
    bit             m_rdy [NW];
    logic [AW-1:0]  m_dp  [NW];
    logic [IXB-1:0] m_idx [NW];
    logic [IDB-1:0] m_id  [NW];
    bit             m_ovf;
    int             m_ovf_wid;
    int             n_vec = 0, n_err = 0;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NW; i++) begin
            m_occ[i] = 0; m_fin[i] = 0; m_rdy[i] = 0;
            m_stk[i].delete();
        end
        m_ovf = 0; m_ovf_wid = 0;
    endfunction

    function automatic int m_free_w();
        for (int i = 0; i < NW; i++) if (!m_occ[i]) return i;
        return -1;
    endfunction

    function automatic int m_done_w();
        for (int i = 0; i < NW; i++)
            if (m_occ[i] && m_fin[i] && ib_all_instr_finished_i[i]) return i;
        return -1;
    endfunction

    function automatic entry_t m_top(int w);
        return m_stk[w][m_stk[w].size() - 1];
    endfunction

    function automatic void model_check();
        logic [NW*PW-1:0] epc;
        logic [NW*WW-1:0] emask;
        logic [NW*AW-1:0] edp;
        logic [NW*IXB-1:0] eidx;
        logic [NW-1:0] erdy;
        int d;
        epc = '0; emask = '0; edp = '0; eidx = '0; erdy = '0;
        for (int i = 0; i < NW; i++) begin
            if (m_occ[i]) begin
                entry_t t;
                t = m_top(i);
                epc[i*PW +: PW] = t.pc;
                emask[i*WW +: WW] = t.mask;
                edp[i*AW +: AW] = m_dp[i];
                eidx[i*IXB +: IXB] = m_idx[i];
                erdy[i] = m_rdy[i] && (t.mask != 0);
            end
        end
        d = m_done_w();
        chk("warp_free", 256'(warp_free_o), 256'(m_free_w() >= 0));
        chk("done_valid", 256'(tblock_done_o), 256'(d >= 0));
        if (d >= 0) chk("done_id", 256'(tblock_done_id_o), 256'(m_id[d]));
        chk("warp_ready", 256'(warp_ready_o), 256'(erdy));
        chk("warp_pc", 256'(warp_pc_o), 256'(epc));
        chk("warp_mask", 256'(warp_act_mask_o), 256'(emask));
        chk("warp_dp", 256'(warp_dp_addr_o), 256'(edp));
        chk("warp_tidx", 256'(warp_tblock_idx_o), 256'(eidx));
        chk("overflow", 256'(stack_overflow_o), 256'(m_ovf));
        if (m_ovf) chk("overflow_wid", 256'(stack_overflow_wid_o), 256'(m_ovf_wid));
    endfunction

    function automatic void model_step();
        int d, f, w;
        d = m_done_w();
        f = m_free_w();
        m_ovf = 0;
        if (d >= 0 && tblock_done_ready_i) begin
            m_occ[d] = 0; m_rdy[d] = 0; m_stk[d].delete();
        end
        if (allocate_warp_i && f >= 0) begin
            entry_t e;
            e.pc = allocate_pc_i; e.mask = '1; e.rpc = '1;
            m_occ[f] = 1; m_fin[f] = 0; m_rdy[f] = 1;
            m_stk[f].delete(); m_stk[f].push_back(e);
            m_dp[f] = allocate_dp_addr_i; m_idx[f] = allocate_tblock_idx_i;
            m_id[f] = allocate_tblock_id_i;
        end
        for (int i = 0; i < NW; i++) if (warp_selected_i[i]) m_rdy[i] = 0;
        if (instruction_decoded_i) begin
            entry_t tos, nt, tk;
            logic [WW-1:0] act, t;
            bit ok;
            w = int'(decode_wid_i);
            tos = m_stk[w].pop_back();
            act = tos.mask;
            t = act & decode_taken_mask_i;
            ok = 0;
            if (decode_stop_warp_i) begin
                m_stk[w].push_back(tos);
                m_fin[w] = 1; m_rdy[w] = 0;
            end else if (decode_branch_i && t != 0 && t != act) begin
                if (m_stk[w].size() + 1 + 2 <= SD) begin
                    tos.pc = decode_reconv_pc_i;
                    nt.pc = decode_next_pc_i; nt.mask = act & ~t; nt.rpc = decode_reconv_pc_i;
                    tk.pc = decode_target_pc_i; tk.mask = t; tk.rpc = decode_reconv_pc_i;
                    m_stk[w].push_back(tos); m_stk[w].push_back(nt); m_stk[w].push_back(tk);
                    ok = 1;
                end else begin
                    m_stk[w].push_back(tos);
                    m_fin[w] = 1; m_rdy[w] = 0; m_ovf = 1; m_ovf_wid = w;
                end
            end else begin
                tos.pc = (decode_branch_i && t == act) ? decode_target_pc_i : decode_next_pc_i;
                m_stk[w].push_back(tos);
                ok = 1;
            end
            if (ok) begin
                m_rdy[w] = !m_fin[w];
                if (m_stk[w].size() > 1 && m_top(w).pc == m_top(w).rpc) void'(m_stk[w].pop_back());
            end
        end
    endfunction

    task automatic idle();
        allocate_warp_i = 0; instruction_decoded_i = 0; decode_stop_warp_i = 0;
        decode_branch_i = 0; warp_selected_i = '0;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_pc"}, 256'(warp_pc_o), 256'(0));
        chk({tag, "_mask"}, 256'(warp_act_mask_o), 256'(0));
        chk({tag, "_ready"}, 256'(warp_ready_o), 256'(0));
        chk({tag, "_done"}, 256'(tblock_done_o), 256'(0));
        chk({tag, "_free"}, 256'(warp_free_o), 256'(0));
        chk({tag, "_ovf"}, 256'(stack_overflow_o), 256'(0));
    endtask

    task automatic do_reset(string tag);
        rst_i = 1; idle();
        #2;
        model_reset();
        check_zero(tag);
        @(negedge clk);
        rst_i = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(logic [PW-1:0] pc, logic [IDB-1:0] id);
        allocate_warp_i = 1; allocate_pc_i = pc; allocate_tblock_id_i = id;
        allocate_dp_addr_i = $urandom; allocate_tblock_idx_i = IXB'($urandom);
    endtask

    task automatic dec(int w, bit stop, bit br, logic [WW-1:0] tk,
                       logic [PW-1:0] nx, logic [PW-1:0] tg, logic [PW-1:0] rc);
        instruction_decoded_i = 1; decode_wid_i = WIDW'(w); decode_stop_warp_i = stop;
        decode_branch_i = br; decode_taken_mask_i = tk; decode_next_pc_i = nx;
        decode_target_pc_i = tg; decode_reconv_pc_i = rc;
    endtask

    typedef struct {
        bit alloc; bit sel; bit dec; bit br;
        logic [PW-1:0] apc, next, target, reconv;
        logic [WW-1:0] taken, emask;
        logic [PW-1:0] epc;
        bit erdy; bit eovf;
    } vec_t;

    function automatic vec_t mk(bit a, bit s, bit d, bit b, logic [PW-1:0] apc,
                                logic [WW-1:0] tk, logic [PW-1:0] nx, logic [PW-1:0] tg,
                                logic [PW-1:0] rc, logic [PW-1:0] epc, logic [WW-1:0] em,
                                bit er, bit eo);
        vec_t v;
        v.alloc = a; v.sel = s; v.dec = d; v.br = b; v.apc = apc; v.taken = tk;
        v.next = nx; v.target = tg; v.reconv = rc; v.epc = epc; v.emask = em;
        v.erdy = er; v.eovf = eo;
        return v;
    endfunction

    vec_t tbl [13];
    localparam int TW = 1;

    initial begin
        int cand [$];
        int w, s;
        ib_all_instr_finished_i = '0; tblock_done_ready_i = 0;
        allocate_pc_i = '0; allocate_dp_addr_i = '0; allocate_tblock_idx_i = '0;
        allocate_tblock_id_i = '0; decode_wid_i = '0; decode_next_pc_i = '0;
        decode_taken_mask_i = '0; decode_target_pc_i = '0; decode_reconv_pc_i = '0;
        idle();

        tbl[0]  = mk(1, 0, 0, 0, 32'h50,  0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 32'h100, 0, 0, 0, 0, 32'h100, '1, 1, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h100, '1, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 0, 32'h104, 0, 0, 32'h104, '1, 1, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h104, '1, 0, 0);
        tbl[5]  = mk(0, 0, 1, 1, 0, 32'h0000FFFF, 32'h104, 32'h200, 32'h300,
                     32'h200, 32'h0000FFFF, 1, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 0, 32'h300, 0, 0, 32'h104, 32'hFFFF0000, 1, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0, 32'h300, 0, 0, 32'h300, '1, 1, 0);
        tbl[8]  = mk(0, 0, 1, 1, 0, '1, 32'h304, 32'h400, 32'h999, 32'h400, '1, 1, 0);
        tbl[9]  = mk(0, 0, 1, 1, 0, 0, 32'h408, 32'h500, 32'h999, 32'h408, '1, 1, 0);
        tbl[10] = mk(0, 0, 1, 1, 0, 32'hF, 32'h40C, 32'h600, 32'h700, 32'h600, 32'hF, 1, 0);
        tbl[11] = mk(0, 0, 1, 1, 0, 32'h3, 32'h604, 32'h800, 32'h900, 32'h600, 32'hF, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h600, 32'hF, 0, 0);

        do_reset("rst0");
        chk("free_after_reset", 256'(warp_free_o), 256'(1));

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].alloc) alloc(tbl[i].apc, IDB'(i));
            if (tbl[i].sel) warp_selected_i = NW'(1) << TW;
            if (tbl[i].dec) dec(TW, 0, tbl[i].br, tbl[i].taken, tbl[i].next, tbl[i].target,
                                tbl[i].reconv);
            step();
            chk($sformatf("row%0d_pc", i), 256'(warp_pc_o[TW*PW +: PW]), 256'(tbl[i].epc));
            chk($sformatf("row%0d_mask", i), 256'(warp_act_mask_o[TW*WW +: WW]),
                256'(tbl[i].emask));
            chk($sformatf("row%0d_ready", i), 256'(warp_ready_o[TW]), 256'(tbl[i].erdy));
            chk($sformatf("row%0d_ovf", i), 256'(stack_overflow_o), 256'(tbl[i].eovf));
            if (tbl[i].eovf) chk("ovf_wid", 256'(stack_overflow_wid_o), 256'(TW));
        end

        // Completion ordering with ready stalls, and alloc alongside a done handshake.
        do_reset("rst1");
        for (int i = 0; i < 4; i++) begin
            alloc(32'h1000 + 32'(i * 16), IDB'(i + 5));
            step();
        end
        dec(1, 1, 0, 0, 0, 0, 0); step();
        dec(3, 1, 0, 0, 0, 0, 0); step();
        ib_all_instr_finished_i = '1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("done_held", 256'(tblock_done_o), 256'(1));
            chk("done_held_id", 256'(tblock_done_id_o), 256'(6));
        end
        tblock_done_ready_i = 1;
        alloc(32'h2000, 4'hC);
        step();
        chk("done_next_id", 256'(tblock_done_id_o), 256'(8));
        chk("freed_w1_pc", 256'(warp_pc_o[1*PW +: PW]), 256'(0));
        chk("alloc_w4_pc", 256'(warp_pc_o[4*PW +: PW]), 256'(32'h2000));
        step();
        chk("done_clear", 256'(tblock_done_o), 256'(0));
        tblock_done_ready_i = 0;
        alloc(32'h3000, 4'h1); step();
        chk("realloc_w1_pc", 256'(warp_pc_o[1*PW +: PW]), 256'(32'h3000));

        // Fill every warp, try one more allocation, then reset mid-divergence.
        for (int i = 0; i < 4; i++) begin
            alloc(32'h4000 + 32'(i), IDB'(i)); step();
        end
        chk("full_no_free", 256'(warp_free_o), 256'(0));
        alloc(32'hDEAD, 4'h2); step();
        dec(0, 0, 1, 32'hFF, 32'h10, 32'hA00, 32'hB00); step();
        chk("div_w0_pc", 256'(warp_pc_o[0 +: PW]), 256'(32'hA00));
        do_reset("rst_mid");
        ib_all_instr_finished_i = '0;

        for (int c = 0; c < 3000; c++) begin
            ib_all_instr_finished_i = NW'($urandom);
            tblock_done_ready_i = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0)
                alloc($urandom, IDB'($urandom));
            cand.delete();
            for (int i = 0; i < NW; i++) if (m_occ[i] && !m_fin[i]) cand.push_back(i);
            w = -1;
            if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
                entry_t t;
                logic [WW-1:0] tk;
                logic [PW-1:0] nx, rc, tg;
                w = cand[$urandom_range(0, cand.size() - 1)];
                t = m_top(w);
                case ($urandom_range(0, 3))
                    0: tk = '0;
                    1: tk = '1;
                    default: tk = $urandom;
                endcase
                rc = 32'h100 * 32'($urandom_range(1, 4));
                nx = ($urandom_range(0, 2) == 0) ? t.rpc : $urandom;
                tg = ($urandom_range(0, 7) == 0) ? rc : $urandom;
                dec(w, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, tk, nx, tg, rc);
            end
            if ($urandom_range(0, 1) == 1) begin
                s = int'($urandom_range(0, NW - 1));
                if (m_occ[s] && s != w) warp_selected_i = NW'(1) << s;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
